// File: rtl/keypad_scanner_if.sv
// Comparator-side keypad interface: BCD digit plus per-class pressed flags.
// The scanner is the master (producer); the comparator is the slave.
interface keypad_scanner_if;
    logic [3:0] data;
    logic       is_pressed;
    logic       is_star_pressed;
    logic       is_hash_pressed;

    modport master (output data, is_pressed, is_star_pressed, is_hash_pressed);
    modport slave  (input  data, is_pressed, is_star_pressed, is_hash_pressed);
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronizer, per-scan debounce FSM,
// and key encoding onto the comparator interface.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              is_on,
    input  logic [3:0]        row,
    output logic [2:0]        col,
    keypad_scanner_if.master  kp
);
    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [3:0]  KeyStar = 4'd10;
    localparam logic [3:0]  KeyHash = 4'd11;

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    logic [3:0]      r_row_meta, r_row_sync;
    logic            r_scan_en;
    logic [DivW-1:0] r_div;
    logic [1:0]      r_idx;
    logic            r_found;
    logic [3:0]      r_found_code;
    state_e          r_state, w_state_next;
    logic [3:0]      r_key, w_key_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [3:0]      r_data, w_data_next;
    logic            r_flag_dig, r_flag_star, r_flag_hash;

    logic            w_slot_end, w_scan_end, w_hit, w_res_valid, w_held;
    logic [1:0]      w_hit_row;
    logic [3:0]      w_hit_code, w_res_code;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        if (r != 2'd3) begin
            return {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        end
        case (c)
            2'd0:    return KeyStar;
            2'd1:    return 4'd0;
            default: return KeyHash;
        endcase
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return k < 4'd10;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_slot_end = r_scan_en && (r_div == DivW'(SCAN_DIV - 1));
    assign w_scan_end = w_slot_end && (r_idx == 2'd2);
    assign w_hit      = w_slot_end && (r_row_sync != 4'hF);

    // Lowest low row wins within the column being sampled.
    always_comb begin
        w_hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_sync[i]) w_hit_row = 2'(i);
        end
    end

    assign w_hit_code  = key_code(w_hit_row, r_idx);
    assign w_res_valid = r_found || w_hit;
    assign w_res_code  = r_found ? r_found_code : w_hit_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_en    <= 1'b0;
            r_div        <= '0;
            r_idx        <= 2'd0;
            r_found      <= 1'b0;
            r_found_code <= 4'd0;
        end else if (!is_on) begin
            r_scan_en <= 1'b0;
            r_div     <= '0;
            r_idx     <= 2'd0;
            r_found   <= 1'b0;
        end else begin
            r_scan_en <= 1'b1;
            if (w_slot_end) begin
                r_div <= '0;
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
                if (w_scan_end) begin
                    r_found <= 1'b0;
                end else if (!r_found && w_hit) begin
                    r_found      <= 1'b1;
                    r_found_code <= w_hit_code;
                end
            end else if (r_scan_en) begin
                r_div <= r_div + DivW'(1);
            end
        end
    end

    always_comb begin
        col = 3'b111;
        if (r_scan_en) col[r_idx] = 1'b0;
    end

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        if (!is_on) begin
            w_state_next = StScan;
            w_cnt_next   = '0;
        end else if (w_scan_end) begin
            unique case (r_state)
                StScan: begin
                    if (w_res_valid) begin
                        w_key_next = w_res_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_next = StPressed;
                            w_cnt_next   = '0;
                            if (is_digit(w_res_code)) w_data_next = w_res_code;
                        end else begin
                            w_state_next = StDebounce;
                            w_cnt_next   = CntW'(1);
                        end
                    end
                end
                StDebounce: begin
                    if (!w_res_valid) begin
                        w_state_next = StScan;
                        w_cnt_next   = '0;
                    end else if (w_res_code == r_key) begin
                        if (r_cnt + CntW'(1) >= CntW'(DEBOUNCE_SCANS)) begin
                            w_state_next = StPressed;
                            w_cnt_next   = '0;
                            // Data lands a cycle ahead of the registered flag.
                            if (is_digit(r_key)) w_data_next = r_key;
                        end else begin
                            w_cnt_next = r_cnt + CntW'(1);
                        end
                    end else begin
                        w_key_next = w_res_code;
                        w_cnt_next = CntW'(1);
                    end
                end
                StPressed: begin
                    if (!w_res_valid || w_res_code != r_key) begin
                        w_state_next = (DEBOUNCE_SCANS == 1) ? StScan : StRelease;
                        w_cnt_next   = (DEBOUNCE_SCANS == 1) ? '0 : CntW'(1);
                    end
                end
                StRelease: begin
                    if (w_res_valid && w_res_code == r_key) begin
                        w_state_next = StPressed;
                        w_cnt_next   = '0;
                    end else if (r_cnt + CntW'(1) >= CntW'(DEBOUNCE_SCANS)) begin
                        w_state_next = StScan;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CntW'(1);
                    end
                end
                default: w_state_next = StScan;
            endcase
        end
    end

    assign w_held = is_on && ((w_state_next == StPressed) || (w_state_next == StRelease));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StScan;
            r_key       <= 4'd0;
            r_cnt       <= '0;
            r_data      <= 4'd0;
            r_flag_dig  <= 1'b0;
            r_flag_star <= 1'b0;
            r_flag_hash <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key       <= w_key_next;
            r_cnt       <= w_cnt_next;
            r_data      <= w_data_next;
            // Flags follow the registered state, one cycle behind the data load.
            r_flag_dig  <= is_on && (r_state == StPressed || r_state == StRelease)
                           && w_held && is_digit(r_key);
            r_flag_star <= is_on && (r_state == StPressed || r_state == StRelease)
                           && w_held && (r_key == KeyStar);
            r_flag_hash <= is_on && (r_state == StPressed || r_state == StRelease)
                           && w_held && (r_key == KeyHash);
        end
    end

    assign kp.data            = r_data;
    assign kp.is_pressed      = r_flag_dig;
    assign kp.is_star_pressed = r_flag_star;
    assign kp.is_hash_pressed = r_flag_hash;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a combinational keypad matrix model.
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_SCANS = 3;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             is_on   = 1'b0;
    logic [3:0]       row;
    logic [2:0]       col;
    logic [3:0][2:0]  keys    = '0;   // keys[r][c] = 1 when that key is held
    int               n_checks = 0;
    int               n_pass   = 0;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .is_on   (is_on),
        .row     (row),
        .col     (col),
        .kp      (kp_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic flag(input int sel);
        case (sel)
            0:       return kp_if.is_pressed;
            1:       return kp_if.is_star_pressed;
            default: return kp_if.is_hash_pressed;
        endcase
    endfunction

    function automatic logic any_flag();
        return kp_if.is_pressed | kp_if.is_star_pressed | kp_if.is_hash_pressed;
    endfunction

    task automatic wait_flag(input int sel, input logic level, input int max_cycles,
                             output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < max_cycles) begin
            step(1);
            cycles++;
            if (flag(sel) === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        is_on   = 1'b1;
        keys    = '0;
        step(2);
        n_checks++;
        if (col !== 3'b111) $display("FAIL reset_col: got %b expected 111", col);
        else n_pass++;
        n_checks++;
        if (kp_if.data !== 4'b0000) $display("FAIL reset_data: got %b expected 0000", kp_if.data);
        else n_pass++;
        n_checks++;
        if ({kp_if.is_pressed, kp_if.is_star_pressed, kp_if.is_hash_pressed} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000",
                     {kp_if.is_pressed, kp_if.is_star_pressed, kp_if.is_hash_pressed});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        step(2);
        n_checks++;
        if (col !== 3'b110) $display("FAIL scan_col0: got %b expected 110", col);
        else n_pass++;
    endtask

    task automatic test_digit_press();
        int  c;
        int  bad;
        bit  ok;
        bit  seen;
        keys[1][1] = 1'b1;
        c = 0;
        seen = 1'b0;
        while (c < 80 && !seen) begin
            step(1);
            c++;
            if (kp_if.data === 4'b0101) seen = 1'b1;
        end
        n_checks++;
        if (!seen || c < 24 || c > 50)
            $display("FAIL digit5_latency: got seen=%0d after %0d cycles expected 24..50", seen, c);
        else n_pass++;
        n_checks++;
        if (kp_if.is_pressed !== 1'b0)
            $display("FAIL digit5_data_lead: is_pressed=%b expected 0 when data loads",
                     kp_if.is_pressed);
        else n_pass++;
        step(1);
        n_checks++;
        if (kp_if.is_pressed !== 1'b1)
            $display("FAIL digit5_rise: is_pressed=%b expected 1", kp_if.is_pressed);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (kp_if.is_pressed !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL digit5_hold: got %0d low cycles expected 0", bad);
        else n_pass++;
        keys = '0;
        wait_flag(0, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok || c < 24 || c > 50)
            $display("FAIL digit5_release: got ok=%0d after %0d cycles expected 24..50", ok, c);
        else n_pass++;
        n_checks++;
        if (kp_if.data !== 4'b0101)
            $display("FAIL digit5_data_kept: got %b expected 0101", kp_if.data);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [2:0] prev;
        int         bad;
        int         rises;
        logic       last;
        prev = col;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (col === 3'b110 && prev !== 3'b110) break;
            prev = col;
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            keys[2][0] = ((i / 5) % 2 == 0);
            step(1);
            if (any_flag()) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bounce_quiet: got %0d flagged cycles expected 0", bad);
        else n_pass++;
        keys[2][0] = 1'b1;
        rises = 0;
        last  = kp_if.is_pressed;
        for (int i = 0; i < 200; i++) begin
            if (i == 120) keys = '0;
            step(1);
            if (kp_if.is_pressed === 1'b1 && last !== 1'b1) rises++;
            last = kp_if.is_pressed;
        end
        n_checks++;
        if (rises != 1) $display("FAIL bounce_single_pulse: got %0d rises expected 1", rises);
        else n_pass++;
        n_checks++;
        if (kp_if.data !== 4'b0111) $display("FAIL bounce_data: got %b expected 0111", kp_if.data);
        else n_pass++;
        n_checks++;
        if (kp_if.is_pressed !== 1'b0)
            $display("FAIL bounce_released: is_pressed=%b expected 0", kp_if.is_pressed);
        else n_pass++;
    endtask

    task automatic test_star_hash();
        int c;
        bit ok;
        keys[3][0] = 1'b1;
        wait_flag(1, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL star_rise: got timeout after %0d cycles expected rise", c);
        else n_pass++;
        n_checks++;
        if ({kp_if.is_pressed, kp_if.is_hash_pressed} !== 2'b00)
            $display("FAIL star_exclusive: got pressed,hash=%b expected 00",
                     {kp_if.is_pressed, kp_if.is_hash_pressed});
        else n_pass++;
        n_checks++;
        if (kp_if.data !== 4'b0111) $display("FAIL star_data: got %b expected 0111", kp_if.data);
        else n_pass++;
        keys = '0;
        wait_flag(1, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL star_fall: got timeout after %0d cycles expected fall", c);
        else n_pass++;
        keys[3][2] = 1'b1;
        wait_flag(2, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL hash_rise: got timeout after %0d cycles expected rise", c);
        else n_pass++;
        n_checks++;
        if ({kp_if.is_pressed, kp_if.is_star_pressed} !== 2'b00)
            $display("FAIL hash_exclusive: got pressed,star=%b expected 00",
                     {kp_if.is_pressed, kp_if.is_star_pressed});
        else n_pass++;
        n_checks++;
        if (kp_if.data !== 4'b0111) $display("FAIL hash_data: got %b expected 0111", kp_if.data);
        else n_pass++;
        keys = '0;
        wait_flag(2, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL hash_fall: got timeout after %0d cycles expected fall", c);
        else n_pass++;
    endtask

    task automatic test_multi_key();
        int c;
        bit ok;
        keys[0][1] = 1'b1;
        keys[2][2] = 1'b1;
        wait_flag(0, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok || kp_if.data !== 4'b0010)
            $display("FAIL multi_first: got ok=%0d data=%b expected 1/0010", ok, kp_if.data);
        else n_pass++;
        keys[0][1] = 1'b0;
        wait_flag(0, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL multi_drop: got timeout after %0d cycles expected fall", c);
        else n_pass++;
        wait_flag(0, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok || kp_if.data !== 4'b1001)
            $display("FAIL multi_second: got ok=%0d data=%b expected 1/1001", ok, kp_if.data);
        else n_pass++;
        keys = '0;
        wait_flag(0, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL multi_release: got timeout after %0d cycles expected fall", c);
        else n_pass++;
    endtask

    task automatic test_is_on();
        int c;
        int bad;
        bit ok;
        keys[0][2] = 1'b1;
        wait_flag(0, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok || kp_if.data !== 4'b0011)
            $display("FAIL on_press3: got ok=%0d data=%b expected 1/0011", ok, kp_if.data);
        else n_pass++;
        is_on = 1'b0;
        step(1);
        n_checks++;
        if (kp_if.is_pressed !== 1'b0 || col !== 3'b111)
            $display("FAIL off_idle: got pressed=%b col=%b expected 0/111",
                     kp_if.is_pressed, col);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (col !== 3'b111 || any_flag()) bad++;
        end
        n_checks++;
        if (bad != 0 || kp_if.data !== 4'b0011)
            $display("FAIL off_hold: got %0d bad cycles data=%b expected 0/0011",
                     bad, kp_if.data);
        else n_pass++;
        is_on = 1'b1;
        wait_flag(0, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok || c < 24)
            $display("FAIL on_reaccept: got ok=%0d after %0d cycles expected >=24", ok, c);
        else n_pass++;
        keys = '0;
        wait_flag(0, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL on_release: got timeout after %0d cycles expected fall", c);
        else n_pass++;
    endtask

    task automatic test_reset_mid_debounce();
        int c;
        int bad;
        bit ok;
        keys[1][2] = 1'b1;
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            step(1);
            if (any_flag()) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rst_pre_quiet: got %0d flagged cycles expected 0", bad);
        else n_pass++;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (col !== 3'b111 || kp_if.data !== 4'b0000 || any_flag())
            $display("FAIL rst_async: got col=%b data=%b flags=%b expected 111/0000/0",
                     col, kp_if.data, any_flag());
        else n_pass++;
        step(2);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (any_flag()) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rst_post_quiet: got %0d flagged cycles expected 0", bad);
        else n_pass++;
        wait_flag(0, 1'b1, 80, c, ok);
        n_checks++;
        if (!ok || kp_if.data !== 4'b0110)
            $display("FAIL rst_reaccept: got ok=%0d data=%b expected 1/0110", ok, kp_if.data);
        else n_pass++;
        keys = '0;
        wait_flag(0, 1'b0, 80, c, ok);
        n_checks++;
        if (!ok) $display("FAIL rst_release: got timeout after %0d cycles expected fall", c);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_digit_press();
        test_bounce();
        test_star_hash();
        test_multi_key();
        test_is_on();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1);
    end
endmodule
